// File: rtl/serial_ripple_subtractor_pkg.sv
// Shared types and defaults for the bit-serial ripple subtractor.
package serial_ripple_subtractor_pkg;

   localparam int c_default_wordlength = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } sub_state_t;

endpackage

// File: rtl/serial_ripple_subtractor_full_subtractor.sv
// One-bit full subtractor, reused for every bit position of the serial datapath.
module full_subtractor (
   input  logic a,
   input  logic b,
   input  logic bi,
   output logic d,
   output logic bo
);

   assign d  = a ^ b ^ bi;
   assign bo = (~a & b) | (~(a ^ b) & bi);

endmodule

// File: rtl/serial_ripple_subtractor.sv
// Bit-serial subtractor: s = a - b - bi, one bit per clock, LSB first.
//
// state | meaning
// IDLE  | ready for operands (in_rd=1)
// RUN   | processing bit idx, one bit per cycle
// DONE  | s/bo valid (out_vld=1), held until out_rd
module serial_ripple_subtractor
   import serial_ripple_subtractor_pkg::*;
#(
   parameter int p_wordlength = c_default_wordlength
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [p_wordlength-1:0] a,
   input  logic [p_wordlength-1:0] b,
   input  logic                    bi,
   input  logic                    in_vld,
   output logic                    in_rd,
   output logic [p_wordlength-1:0] s,
   output logic                    bo,
   output logic                    out_vld,
   input  logic                    out_rd
);

   if (p_wordlength < 1) begin : g_bad_width
      $error("serial_ripple_subtractor: p_wordlength must be at least 1");
   end

   localparam int c_idx_w = $clog2(p_wordlength) + 1;
   localparam logic [c_idx_w-1:0] c_last_idx = c_idx_w'(p_wordlength - 1);

   sub_state_t state, state_nxt;

   logic [p_wordlength-1:0] a_sh;
   logic [p_wordlength-1:0] b_sh;
   logic [p_wordlength-1:0] s_reg;
   logic [p_wordlength:0]   s_cat;
   logic [c_idx_w-1:0]      idx;
   logic                    br;
   logic                    bo_reg;
   logic                    fs_d;
   logic                    fs_bo;
   logic                    last_bit;

   // Operands shift right so the active bit is always at position 0.
   full_subtractor u_fs (
      .a  (a_sh[0]),
      .b  (b_sh[0]),
      .bi (br),
      .d  (fs_d),
      .bo (fs_bo)
   );

   assign last_bit = (idx == c_last_idx);
   assign s_cat    = {fs_d, s_reg};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (in_vld) state_nxt = RUN;
         RUN:     if (last_bit) state_nxt = DONE;
         DONE:    if (out_rd) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_sh   <= '0;
         b_sh   <= '0;
         s_reg  <= '0;
         idx    <= '0;
         br     <= 1'b0;
         bo_reg <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_vld) begin
                  a_sh  <= a;
                  b_sh  <= b;
                  br    <= bi;
                  idx   <= '0;
                  s_reg <= '0;
               end
            end
            RUN: begin
               a_sh  <= a_sh >> 1;
               b_sh  <= b_sh >> 1;
               br    <= fs_bo;
               // Difference bits enter at the MSB; after W shifts bit i sits at i.
               s_reg <= s_cat[p_wordlength:1];
               if (last_bit) begin
                  bo_reg <= fs_bo;
               end else begin
                  idx <= idx + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign in_rd   = (state == IDLE);
   assign out_vld = (state == DONE);
   assign s       = s_reg;
   assign bo      = bo_reg;

endmodule

// File: tb/tb_serial_ripple_subtractor.sv
// Self-checking bench for serial_ripple_subtractor at W=4: vector table, corner sequences, random model checks.
module tb_serial_ripple_subtractor;

   localparam int W = 4;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic [W-1:0] a = '0;
   logic [W-1:0] b = '0;
   logic         bi = 1'b0;
   logic         in_vld = 1'b0;
   logic         in_rd;
   logic [W-1:0] s;
   logic         bo;
   logic         out_vld;
   logic         out_rd = 1'b0;

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct {
      int a;
      int b;
      int bi;
      int s;
      int bo;
   } vec_t;

   vec_t vecs[6];

   serial_ripple_subtractor #(.p_wordlength(W)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .a       (a),
      .b       (b),
      .bi      (bi),
      .in_vld  (in_vld),
      .in_rd   (in_rd),
      .s       (s),
      .bo      (bo),
      .out_vld (out_vld),
      .out_rd  (out_rd)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Reference: plain integer arithmetic on the unsigned operands.
   function automatic void model(input int ma, input int mb, input int mbi,
                                 output int ms, output int mbo);
      int diff;
      diff = ma - mb - mbi;
      ms   = (diff + 4 * (1 << W)) % (1 << W);
      mbo  = (diff < 0) ? 1 : 0;
   endfunction

   // Called at a negedge; returns result and edges from acceptance to out_vld.
   task automatic run_txn(input int ta, input int tbv, input int tbi,
                          output int rs, output int rbo, output int lat);
      int n;
      n = 0;
      while (!in_rd && n < 20) begin
         @(negedge clk);
         n++;
      end
      a      = ta[W-1:0];
      b      = tbv[W-1:0];
      bi     = tbi[0];
      in_vld = 1'b1;
      @(negedge clk);
      in_vld = 1'b0;
      a      = W'($urandom);
      b      = W'($urandom);
      bi     = 1'($urandom);
      lat    = 0;
      while (!out_vld && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      rs     = int'(s);
      rbo    = int'(bo);
      out_rd = 1'b1;
      @(negedge clk);
      out_rd = 1'b0;
   endtask

   initial begin
      int rs, rbo, lat, es, ebo, n, last, results;
      int ra, rb, rbi;
      int exp_s_q[$];
      int exp_bo_q[$];

      vecs[0] = '{a: 9,  b: 3,  bi: 0, s: 6,  bo: 0};
      vecs[1] = '{a: 3,  b: 9,  bi: 0, s: 10, bo: 1};
      vecs[2] = '{a: 0,  b: 0,  bi: 1, s: 15, bo: 1};
      vecs[3] = '{a: 15, b: 15, bi: 1, s: 15, bo: 1};
      vecs[4] = '{a: 15, b: 0,  bi: 0, s: 15, bo: 0};
      vecs[5] = '{a: 7,  b: 7,  bi: 0, s: 0,  bo: 0};

      // Reset state
      @(negedge clk);
      @(negedge clk);
      check("rst_in_rd", int'(in_rd), 1);
      check("rst_out_vld", int'(out_vld), 0);
      check("rst_s", int'(s), 0);
      check("rst_bo", int'(bo), 0);
      rst_n = 1'b1;

      // Directed vector table
      for (int i = 0; i < 6; i++) begin
         run_txn(vecs[i].a, vecs[i].b, vecs[i].bi, rs, rbo, lat);
         check($sformatf("vec%0d_s", i), rs, vecs[i].s);
         check($sformatf("vec%0d_bo", i), rbo, vecs[i].bo);
         check($sformatf("vec%0d_latency", i), lat, W);
      end

      // Random transactions against the arithmetic model
      for (int i = 0; i < 20; i++) begin
         ra  = int'($urandom_range(0, 15));
         rb  = int'($urandom_range(0, 15));
         rbi = int'($urandom_range(0, 1));
         model(ra, rb, rbi, es, ebo);
         run_txn(ra, rb, rbi, rs, rbo, lat);
         check($sformatf("rnd%0d_s", i), rs, es);
         check($sformatf("rnd%0d_bo", i), rbo, ebo);
      end

      // DONE hold with out_rd low; new in_vld must be ignored
      check("hold_start_in_rd", int'(in_rd), 1);
      a = 4'd9; b = 4'd3; bi = 1'b0; in_vld = 1'b1;
      @(negedge clk);
      in_vld = 1'b0;
      n = 0;
      while (!out_vld && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("hold_latency", n, W);
      a = 4'd1; b = 4'd2; bi = 1'b1; in_vld = 1'b1;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         check($sformatf("hold%0d_s", k), int'(s), 6);
         check($sformatf("hold%0d_bo", k), int'(bo), 0);
         check($sformatf("hold%0d_out_vld", k), int'(out_vld), 1);
         check($sformatf("hold%0d_in_rd", k), int'(in_rd), 0);
      end
      in_vld = 1'b0;
      out_rd = 1'b1;
      @(negedge clk);
      out_rd = 1'b0;
      check("hold_release_in_rd", int'(in_rd), 1);
      check("hold_release_out_vld", int'(out_vld), 0);

      // Reset asserted in the second RUN cycle
      a = 4'd9; b = 4'd3; bi = 1'b0; in_vld = 1'b1;
      @(negedge clk);
      in_vld = 1'b0;
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("midrst_s", int'(s), 0);
      check("midrst_bo", int'(bo), 0);
      check("midrst_out_vld", int'(out_vld), 0);
      check("midrst_in_rd", int'(in_rd), 1);
      @(negedge clk);
      rst_n = 1'b1;
      run_txn(5, 2, 0, rs, rbo, lat);
      check("postrst_s", rs, 3);
      check("postrst_bo", rbo, 0);
      check("postrst_latency", lat, W);

      // Back-to-back with in_vld and out_rd held high
      a = W'($urandom); b = W'($urandom); bi = 1'($urandom);
      in_vld  = 1'b1;
      out_rd  = 1'b1;
      last    = -1;
      results = 0;
      for (int c = 0; c < 64; c++) begin
         if (out_vld) begin
            check("b2b_in_flight", exp_s_q.size(), 1);
            if (exp_s_q.size() > 0) begin
               es  = exp_s_q.pop_front();
               ebo = exp_bo_q.pop_front();
               check($sformatf("b2b%0d_s", results), int'(s), es);
               check($sformatf("b2b%0d_bo", results), int'(bo), ebo);
            end
            if (last >= 0) check($sformatf("b2b%0d_period", results), c - last, W + 2);
            last = c;
            results++;
         end
         if (in_rd) begin
            model(int'(a), int'(b), int'(bi), es, ebo);
            exp_s_q.push_back(es);
            exp_bo_q.push_back(ebo);
         end else begin
            a  = W'($urandom);
            b  = W'($urandom);
            bi = 1'($urandom);
         end
         @(negedge clk);
      end
      in_vld = 1'b0;
      out_rd = 1'b0;
      check("b2b_count", results, 10);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/serial_ripple_subtractor.md
SERIAL_RIPPLE_SUBTRACTOR -- requirements
Module: serial_ripple_subtractor

Interface
REQ-001 The block SHALL have parameter p_wordlength, default 4, giving the operand/result width W in bits (W >= 1).
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1, reset that is asynchronous and active-low.
REQ-004 The block SHALL have port a, input, W, the minuend.
REQ-005 The block SHALL have port b, input, W, the subtrahend.
REQ-006 The block SHALL have port bi, input, 1, the borrow-in.
REQ-007 The block SHALL have port in_vld, input, 1, meaning operands valid.
REQ-008 The block SHALL have port in_rd, output, 1, meaning the block accepts operands.
REQ-009 The block SHALL have port s, output, W, the difference.
REQ-010 The block SHALL have port bo, output, 1, the borrow-out.
REQ-011 The block SHALL have port out_vld, output, 1, meaning s and bo are valid.
REQ-012 The block SHALL have port out_rd, input, 1, meaning the consumer accepts the result.

Function
REQ-013 The block SHALL implement FSM states IDLE, RUN, DONE.
REQ-014 in_rd SHALL be 1 iff state == IDLE, and out_vld SHALL be 1 iff state == DONE; inputs are not accepted while busy.
REQ-015 On a clk edge in IDLE with in_vld=1, the block SHALL latch a, b and bi (borrow register), clear bit index i to 0, clear the result shift register, and enter RUN.
REQ-016 Each RUN cycle SHALL process bit i: d = a[i]^b[i]^br; br_next = (~a[i]&b[i]) | (~(a[i]^b[i])&br); d is stored as result bit i.
REQ-017 After processing bit W-1, the block SHALL latch bo = br_next and enter DONE; RUN lasts exactly W cycles, so out_vld rises W edges after the accepting edge.
REQ-018 In DONE, s and bo SHALL hold stable until an edge with out_rd=1, after which the block SHALL return to IDLE; there is no bypass from DONE directly to RUN.
REQ-019 Result semantics SHALL be s = (a - b - bi) mod 2^W and bo = 1 iff a < b + bi (unsigned).
REQ-020 The bit index SHALL be ceil(log2(W))+1 bits wide (minimum 1) and SHALL never exceed W-1.
REQ-021 Changes on a, b or bi after acceptance SHALL NOT affect the result in flight.
REQ-022 out_rd while not in DONE and in_vld while not in IDLE SHALL be ignored.

Reset
REQ-023 rst_n=0 SHALL immediately force state=IDLE, i=0, borrow register=0, s=0, bo=0, out_vld=0 and in_rd=1 (after deassertion), including mid-RUN; a partial result is discarded.
REQ-024 The first edge after rst_n deasserts SHALL accept a new operand if in_vld=1.

Structure
REQ-025 A shared package SHALL hold the FSM state enumeration type and the default width constant.
REQ-026 One sub-module full_subtractor (inputs a, b, bi; outputs d, bo; purely combinational) SHALL be instantiated once and reused across all bit positions.
REQ-027 Elaboration SHALL raise an error when p_wordlength < 1.

Verification (W=4)
REQ-028 A bench SHALL apply a=9, b=3, bi=0 and check that out_vld rises 4 edges after acceptance with s=6 and bo=0.
REQ-029 A bench SHALL apply a=3, b=9, bi=0 and check s=10, bo=1; and a=0, b=0, bi=1 and check s=15, bo=1.
REQ-030 A bench SHALL apply a=15, b=15, bi=1 and check s=15, bo=1; and a=15, b=0, bi=0 and check s=15, bo=0.
REQ-031 A bench SHALL hold out_rd=0 for 5 cycles in DONE and check that s, bo and out_vld stay stable, in_rd=0, and a new in_vld is ignored; after out_rd=1 for one edge, in_rd=1.
REQ-032 A bench SHALL assert rst_n=0 in the second RUN cycle and check all outputs zero and in_rd=1; then apply a=5, b=2, bi=0 and check s=3, bo=0.
REQ-033 A bench SHALL issue back-to-back transactions with in_vld and out_rd held at 1 and check one result every W+2 cycles, each correct.
